// File: rtl/line_backing_mem_if.sv
// Request/response bundle between the cache (master) and line_backing_mem (slave).
// A whole line moves per access: wr_line is sampled at acceptance, rd_line is held after gnt.
interface line_backing_mem_if #(
  parameter int LINE_ADDR_LEN = 5,
  parameter int ADDR_LEN      = 10
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

  logic                gnt;
  logic [ADDR_LEN-1:0] addr;
  logic                rd_req;
  logic [31:0]         rd_line [LINE_SIZE];
  logic                wr_req;
  logic [31:0]         wr_line [LINE_SIZE];

  modport master (input gnt, rd_line, output addr, rd_req, wr_req, wr_line);
  modport slave  (output gnt, rd_line, input addr, rd_req, wr_req, wr_line);
endinterface

// File: rtl/line_backing_mem.sv
// Line-granular backing memory with fixed read/write latency and a one-cycle gnt pulse.
// Define LINE_MEM_PATTERN_INIT_EN to start each word at (line << LINE_ADDR_LEN) | word instead of 0.
module line_backing_mem #(
  parameter int LINE_ADDR_LEN = 5,
  parameter int ADDR_LEN      = 10,
  parameter int RD_LATENCY    = 50,
  parameter int WR_LATENCY    = 50
) (
  input  logic             clk,
  input  logic             rst,
  line_backing_mem_if.slave bus
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int DEPTH     = 1 << ADDR_LEN;
  localparam int LW        = 32 * LINE_SIZE;
  localparam logic [7:0] RD_CNT = 8'(RD_LATENCY - 1);
  localparam logic [7:0] WR_CNT = 8'(WR_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, GNT} state_t;

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic                op_wr_reg, op_wr_next;
  logic [ADDR_LEN-1:0] addr_reg, addr_next;
  logic [LW-1:0]       wr_buf_reg, wr_buf_next;
  logic                gnt_reg, gnt_next;
  logic [LW-1:0]       rd_line_reg;

  logic [LW-1:0]       wr_flat;
  logic [7:0]          lat_sel;
  logic                commit, commit_wr;
  logic [ADDR_LEN-1:0] commit_addr;
  logic [LW-1:0]       commit_line;
  logic [LW-1:0]       read_line;

  genvar gi;
  generate
    for (gi = 0; gi < LINE_SIZE; gi++) begin : g_words
      assign wr_flat[gi*32 +: 32] = bus.wr_line[gi];
      assign bus.rd_line[gi]      = rd_line_reg[gi*32 +: 32];
    end
  endgenerate

  assign bus.gnt = gnt_reg;

`ifdef LINE_MEM_PATTERN_INIT_EN
  // Lines never written read back their address pattern; the array itself starts undefined.
  logic [LW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] written = '0;

  function automatic logic [LW-1:0] pattern_line(input logic [ADDR_LEN-1:0] a);
    logic [LW-1:0] l;
    for (int w = 0; w < LINE_SIZE; w++) begin
      l[w*32 +: 32] = (32'(a) << LINE_ADDR_LEN) | 32'(w);
    end
    return l;
  endfunction

  assign read_line = written[commit_addr] ? mem[commit_addr] : pattern_line(commit_addr);

  always_ff @(posedge clk) begin
    if (!rst && commit && commit_wr) begin
      mem[commit_addr]     <= commit_line;
      written[commit_addr] <= 1'b1;
    end
  end
`else
  logic [LW-1:0] mem [DEPTH] = '{default: '0};

  assign read_line = mem[commit_addr];

  always_ff @(posedge clk) begin
    if (!rst && commit && commit_wr) begin
      mem[commit_addr] <= commit_line;
    end
  end
`endif

  // A latency of 1 commits straight from IDLE, using the live address and line.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_wr_next  = op_wr_reg;
    addr_next   = addr_reg;
    wr_buf_next = wr_buf_reg;
    gnt_next    = 1'b0;
    lat_sel     = bus.rd_req ? RD_CNT : WR_CNT;
    commit      = 1'b0;
    commit_wr   = op_wr_reg;
    commit_addr = addr_reg;
    commit_line = wr_buf_reg;
    case (state_reg)
      IDLE: begin
        if (bus.rd_req || bus.wr_req) begin
          op_wr_next = !bus.rd_req;
          addr_next  = bus.addr;
          cnt_next   = lat_sel;
          if (!bus.rd_req) wr_buf_next = wr_flat;
          if (lat_sel == 8'd0) begin
            state_next  = GNT;
            gnt_next    = 1'b1;
            commit      = 1'b1;
            commit_wr   = !bus.rd_req;
            commit_addr = bus.addr;
            commit_line = wr_flat;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 8'd1) begin
          cnt_next   = 8'd0;
          state_next = GNT;
          gnt_next   = 1'b1;
          commit     = 1'b1;
        end else if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      GNT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= 8'd0;
      op_wr_reg  <= 1'b0;
      addr_reg   <= '0;
      wr_buf_reg <= '0;
      gnt_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_wr_reg  <= op_wr_next;
      addr_reg   <= addr_next;
      wr_buf_reg <= wr_buf_next;
      gnt_reg    <= gnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_line_reg <= '0;
    end else if (commit && !commit_wr) begin
      rd_line_reg <= read_line;
    end
  end
endmodule

// File: tb/tb_line_backing_mem.sv
// Directed bench for line_backing_mem: latency-50, latency-4 and latency-1 instances.
// Table vectors on the latency-4 instance plus hand sequences for hold, reset and arbitration cases.
module tb_line_backing_mem;
  logic clk = 1'b0;
  logic rst50, rst4, rst1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_backing_mem_if #(.LINE_ADDR_LEN(5), .ADDR_LEN(10)) bus50 ();
  line_backing_mem_if #(.LINE_ADDR_LEN(5), .ADDR_LEN(10)) bus4 ();
  line_backing_mem_if #(.LINE_ADDR_LEN(5), .ADDR_LEN(10)) bus1 ();

  line_backing_mem #(.LINE_ADDR_LEN(5), .ADDR_LEN(10), .RD_LATENCY(50), .WR_LATENCY(50))
    dut50 (.clk(clk), .rst(rst50), .bus(bus50));
  line_backing_mem #(.LINE_ADDR_LEN(5), .ADDR_LEN(10), .RD_LATENCY(4), .WR_LATENCY(4))
    dut4 (.clk(clk), .rst(rst4), .bus(bus4));
  line_backing_mem #(.LINE_ADDR_LEN(5), .ADDR_LEN(10), .RD_LATENCY(1), .WR_LATENCY(1))
    dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  typedef struct {
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] base;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] init_word(input int a, input int w);
`ifdef LINE_MEM_PATTERN_INIT_EN
    return 32'((a << 5) | w);
`else
    return 32'(a * 0 + w * 0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One access on the latency-4 instance; returns in the idle cycle after gnt.
  task automatic acc4(input bit w, input logic [9:0] a, input logic [31:0] base, output int lat);
    bus4.addr = a;
    if (w) begin
      bus4.wr_req = 1'b1;
      for (int i = 0; i < 32; i++) bus4.wr_line[i] = base + 32'(i);
    end else begin
      bus4.rd_req = 1'b1;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus4.gnt !== 1'b1 && lat < 20);
    bus4.rd_req = 1'b0;
    bus4.wr_req = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] or_line4();
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++) acc |= bus4.rd_line[i];
    return acc;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int prev_idx;
    logic [31:0] prev_exp;
    bit have_rd;

    vecs[0] = '{1'b1, 10'd5,    32'hA000, 0,  32'h0};
    vecs[1] = '{1'b0, 10'd5,    32'h0,    7,  32'hA007};
    vecs[2] = '{1'b0, 10'd6,    32'h0,    0,  init_word(6, 0)};
    vecs[3] = '{1'b1, 10'd0,    32'h1000, 0,  32'h0};
    vecs[4] = '{1'b1, 10'd1023, 32'h2000, 0,  32'h0};
    vecs[5] = '{1'b0, 10'd1023, 32'h0,    31, 32'h201F};
    vecs[6] = '{1'b0, 10'd0,    32'h0,    0,  32'h1000};
    vecs[7] = '{1'b0, 10'd5,    32'h0,    31, 32'hA01F};

    {rst50, rst4, rst1} = 3'b111;
    bus50.rd_req = 0; bus50.wr_req = 0; bus50.addr = '0;
    bus4.rd_req  = 0; bus4.wr_req  = 0; bus4.addr  = '0;
    bus1.rd_req  = 0; bus1.wr_req  = 0; bus1.addr  = '0;
    for (int i = 0; i < 32; i++) begin
      bus50.wr_line[i] = '0; bus4.wr_line[i] = '0; bus1.wr_line[i] = '0;
    end
    tick();
    tick();
    chk("reset_gnt50", 32'(bus50.gnt), 32'd0);
    chk("reset_gnt4", 32'(bus4.gnt), 32'd0);
    chk("reset_gnt1", 32'(bus1.gnt), 32'd0);
    chk("reset_rd_line4", or_line4(), 32'd0);
    {rst50, rst4, rst1} = 3'b000;

    // Latency 50: request raised in cycle 10, gnt only in cycle 60, rd_line held to 100.
    for (int k = 1; k <= 10; k++) tick();
    bus50.addr = 10'd3;
    bus50.rd_req = 1'b1;
    for (int k = 11; k <= 100; k++) begin
      tick();
      chk($sformatf("gnt50_c%0d", k), 32'(bus50.gnt), (k == 60) ? 32'd1 : 32'd0);
      if (k == 60) bus50.rd_req = 1'b0;
      if (k >= 60) begin
        chk($sformatf("rd50_w0_c%0d", k), bus50.rd_line[0], init_word(3, 0));
        chk($sformatf("rd50_w31_c%0d", k), bus50.rd_line[31], init_word(3, 31));
      end
    end
    $display("txn lat50 read addr=3 done");

    // Latency 1: write line 1023, then a held read grants every other cycle.
    bus1.addr = 10'd1023;
    bus1.wr_req = 1'b1;
    for (int i = 0; i < 32; i++) bus1.wr_line[i] = 32'h7FE0 + 32'(i);
    tick();
    chk("gnt1_wr", 32'(bus1.gnt), 32'd1);
    bus1.wr_req = 1'b0;
    tick();
    bus1.rd_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("gnt1_c%0d", k), 32'(bus1.gnt), 32'(k % 2));
      if (k % 2 == 1) chk($sformatf("rd1_w31_c%0d", k), bus1.rd_line[31], 32'h7FFF);
    end
    bus1.rd_req = 1'b0;
    tick();
    $display("txn lat1 held read addr=1023 done");

    // Latency 4 table.
    have_rd = 1'b0;
    prev_idx = 0;
    prev_exp = '0;
    for (int v = 0; v < 8; v++) begin
      acc4(vecs[v].wr, vecs[v].addr, vecs[v].base, lat);
      $display("txn vec%0d %s addr=%0d lat=%0d", v, vecs[v].wr ? "wr" : "rd", vecs[v].addr, lat);
      chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd4);
      if (!vecs[v].wr) begin
        chk($sformatf("vec%0d_rd_w%0d", v, vecs[v].idx), bus4.rd_line[vecs[v].idx], vecs[v].exp);
        have_rd = 1'b1;
        prev_idx = vecs[v].idx;
        prev_exp = vecs[v].exp;
      end else if (have_rd) begin
        chk($sformatf("vec%0d_rd_hold", v), bus4.rd_line[prev_idx], prev_exp);
      end
    end

    // Changes to addr/wr_line after acceptance and an early request drop are ignored.
    bus4.addr = 10'd2;
    bus4.wr_req = 1'b1;
    for (int i = 0; i < 32; i++) bus4.wr_line[i] = 32'hB000 + 32'(i);
    tick();
    chk("drop_gnt_c1", 32'(bus4.gnt), 32'd0);
    bus4.addr = 10'd3;
    for (int i = 0; i < 32; i++) bus4.wr_line[i] = 32'hFFFF_FFFF;
    tick();
    chk("drop_gnt_c2", 32'(bus4.gnt), 32'd0);
    bus4.wr_req = 1'b0;
    tick();
    chk("drop_gnt_c3", 32'(bus4.gnt), 32'd0);
    tick();
    chk("drop_gnt_c4", 32'(bus4.gnt), 32'd1);
    tick();
    acc4(1'b0, 10'd2, 32'h0, lat);
    chk("drop_rd2_w0", bus4.rd_line[0], 32'hB000);
    chk("drop_rd2_w9", bus4.rd_line[9], 32'hB009);
    acc4(1'b0, 10'd3, 32'h0, lat);
    chk("drop_rd3_w0", bus4.rd_line[0], init_word(3, 0));
    $display("txn late-change write addr=2 done");

    // Simultaneous read and write: read first, write accepted after the GNT cycle.
    bus4.addr = 10'd8;
    bus4.rd_req = 1'b1;
    bus4.wr_req = 1'b1;
    for (int i = 0; i < 32; i++) bus4.wr_line[i] = 32'hC000 + 32'(i);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("both_gnt_c%0d", k), 32'(bus4.gnt), (k == 4 || k == 9) ? 32'd1 : 32'd0);
      if (k == 4) begin
        chk("both_rd8_w0", bus4.rd_line[0], init_word(8, 0));
        bus4.rd_req = 1'b0;
      end
    end
    chk("both_rd_hold", bus4.rd_line[0], init_word(8, 0));
    bus4.wr_req = 1'b0;
    tick();
    acc4(1'b0, 10'd8, 32'h0, lat);
    chk("both_rd8_after", bus4.rd_line[0], 32'hC000);
    $display("txn read-wins addr=8 done");

    // Reset mid-write discards the write and clears rd_line.
    bus4.addr = 10'd7;
    bus4.wr_req = 1'b1;
    for (int i = 0; i < 32; i++) bus4.wr_line[i] = 32'hD000 + 32'(i);
    tick();
    tick();
    rst4 = 1'b1;
    tick();
    chk("rst_gnt_c3", 32'(bus4.gnt), 32'd0);
    chk("rst_rd_line", or_line4(), 32'd0);
    rst4 = 1'b0;
    bus4.wr_req = 1'b0;
    for (int k = 4; k <= 9; k++) begin
      tick();
      chk($sformatf("rst_gnt_c%0d", k), 32'(bus4.gnt), 32'd0);
    end
    acc4(1'b0, 10'd7, 32'h0, lat);
    chk("rst_rd7_lat", 32'(lat), 32'd4);
    chk("rst_rd7_w0", bus4.rd_line[0], init_word(7, 0));
    $display("txn reset-abort write addr=7 done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
